// File: rtl/adder_arbiter_pkg.sv
// Shared constants and types for the arbitrated adder.
// Default sizes, FSM state encoding and an id-width helper.
package adder_arbiter_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_CNT_WIDTH = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  function automatic int id_width(int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_arbiter_adder.sv
// Plain WIDTH-bit adder shared by all requesters.
// Carry is derived by the caller from the operand and sum MSBs.
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/adder_arbiter_rr.sv
// Round-robin arbiter: search starts one past the last grant.
// Pointer moves only when advance is high.
module rr_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int IDW = id_width(NUM_REQ);

  logic [IDW-1:0] last;
  logic [IDW-1:0] grant_idx;

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if ((grant == '0) && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
      end
    end
  end

  // Reset pointer to the top index so requester 0 wins first.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last <= IDW'(NUM_REQ - 1);
    end else if (advance) begin
      last <= grant_idx;
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Multi-requester adder: one shared adder, round-robin grant,
// single result register with valid/ready back-pressure.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter  int WIDTH     = DEF_WIDTH,
  parameter  int NUM_REQ   = DEF_NUM_REQ,
  parameter  int CNT_WIDTH = DEF_CNT_WIDTH,
  localparam int IDW       = id_width(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_carry,
  output logic                     busy,
  output logic [CNT_WIDTH-1:0]     op_count
);

  state_t state;
  state_t next_state;

  logic               accept_en;
  logic               accept;
  logic               handshake;
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     sel_id;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   sum;
  logic               carry;

  assign rsp_valid = (state == FULL);
  assign busy      = rsp_valid;
  assign handshake = rsp_valid && rsp_ready;
  assign accept_en = !rsp_valid || rsp_ready;

  // Masking the request vector keeps grants off during reset and stall.
  assign arb_req   = (reset_n && accept_en) ? req_valid : '0;
  assign req_ready = grant;
  assign accept    = |grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (arb_req),
    .advance (accept),
    .grant   (grant)
  );

  always_comb begin
    op_a   = '0;
    op_b   = '0;
    sel_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        op_a   = req_a[i*WIDTH +: WIDTH];
        op_b   = req_b[i*WIDTH +: WIDTH];
        sel_id = IDW'(i);
      end
    end
  end

  adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a   (op_a),
    .b   (op_b),
    .sum (sum)
  );

  // Carry-out recovered from the MSBs of operands and sum.
  assign carry = (op_a[WIDTH-1] & op_b[WIDTH-1])
               | ((op_a[WIDTH-1] | op_b[WIDTH-1]) & ~sum[WIDTH-1]);

  always_comb begin
    next_state = state;
    unique case (state)
      EMPTY: if (accept) next_state = FULL;
      FULL:  if (handshake && !accept) next_state = EMPTY;
      default: next_state = EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= EMPTY;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        rsp_id     <= sel_id;
        rsp_result <= sum;
        rsp_carry  <= carry;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_count <= '0;
    end else if (handshake && (op_count != '1)) begin
      op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 The block SHALL have parameters: WIDTH, 32, operand/result width; NUM_REQ, 4, requester count (2..8); CNT_WIDTH, 16, completed-operation counter width.
REQ-002 clock  input  1  single clock, all state on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  NUM_REQ  per-requester add request.
REQ-005 req_a  input  NUM_REQ*WIDTH  operand A, requester i in bits [i*WIDTH +: WIDTH].
REQ-006 req_b  input  NUM_REQ*WIDTH  operand B, same packing.
REQ-007 req_ready  output  NUM_REQ  one-hot (or zero) grant; request i accepted when req_valid[i] && req_ready[i].
REQ-008 rsp_valid  output  1  result register holds a valid result.
REQ-009 rsp_ready  input  1  consumer accepts result when rsp_valid && rsp_ready.
REQ-010 rsp_id  output  max(1,$clog2(NUM_REQ))  index of requester owning the result.
REQ-011 rsp_result  output  WIDTH  sum modulo 2^WIDTH.
REQ-012 rsp_carry  output  1  unsigned carry-out of the sum.
REQ-013 busy  output  1  high whenever rsp_valid is high.
REQ-014 op_count  output  CNT_WIDTH  number of completed response handshakes, saturating.

Function
REQ-015 One shared adder SHALL serve all requesters; at most one request accepted per cycle.
REQ-016 Accept-enable SHALL be (!rsp_valid || rsp_ready); when low, req_ready SHALL be all-zero.
REQ-017 When accept-enable is high, req_ready SHALL be one-hot on the round-robin winner among asserted req_valid bits; zero if none valid.
REQ-018 Round-robin: search starts at index (last_grant+1) mod NUM_REQ upward with wrap; last_grant updates only on an accepted request.
REQ-019 req_ready SHALL be combinational from req_valid, rsp_valid, rsp_ready and the pointer; no dependency of req_valid on req_ready is required.
REQ-020 Latency: request accepted in cycle N SHALL appear on rsp_valid/rsp_id/rsp_result/rsp_carry in cycle N+1.
REQ-021 FSM states: EMPTY (rsp_valid=0), FULL (rsp_valid=1). EMPTY->FULL on accept; FULL->EMPTY on response handshake without accept; FULL->FULL on response handshake with accept (back-to-back, 1 result/cycle) or while rsp_ready low.
REQ-022 While FULL and rsp_ready low, all rsp_* outputs SHALL hold stable.
REQ-023 rsp_carry SHALL equal bit WIDTH of the (WIDTH+1)-bit zero-extended sum of the accepted operands.
REQ-024 op_count SHALL increment by 1 on each rsp_valid && rsp_ready cycle and hold at 2^CNT_WIDTH-1.
REQ-025 req_valid deasserted by a requester without grant SHALL be dropped with no side effect.

Reset
REQ-026 Assertion of reset_n low SHALL immediately force: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_carry=0, op_count=0, busy=0, state EMPTY, last_grant=NUM_REQ-1 (requester 0 highest priority first).
REQ-027 A result pending at reset SHALL be discarded; req_ready is all-zero while reset_n is low.
REQ-028 Reset deassertion SHALL be synchronised by the integrating design; block takes no action on the release edge.

Structure
REQ-029 State enum (EMPTY/FULL) and default parameter values SHALL live in the shared constants package.
REQ-030 The sum SHALL be computed by one instance of the team's existing adder module (name: u_adder, WIDTH-bit), operands muxed by the grant; carry derived alongside.
REQ-031 Round-robin grant logic SHALL be one sub-module, rr_arbiter (NUM_REQ parameter, req/grant/advance ports).

Verification
REQ-032 Single request: req_valid=4'b0001, a=32'h0000_0005, b=32'h0000_0003 -> req_ready=4'b0001 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=32'h8, rsp_carry=0.
REQ-033 Overflow: a=32'hFFFF_FFFF, b=32'h0000_0002 on requester 2 -> rsp_result=32'h1, rsp_carry=1, rsp_id=2.
REQ-034 Fairness: req_valid=4'b1111 held, rsp_ready=1, after reset -> grants 0,1,2,3,0 on consecutive cycles; rsp_valid stays 1 from cycle 2 onward.
REQ-035 Backpressure: result pending, rsp_ready=0 for 3 cycles with req_valid=4'b0010 -> req_ready=0, rsp_* stable; rsp_ready=1 -> requester 1 granted same cycle, its result next cycle.
REQ-036 Reset mid-operation: rsp_valid=1, op_count=5, reset_n pulsed low between clock edges -> rsp_valid=0, op_count=0 immediately; after release first grant of 4'b1001 goes to requester 0.
REQ-037 Saturation: CNT_WIDTH=4, 17 response handshakes -> op_count reaches 4'hF and holds.
